uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between `N_REQ` byte-stream requesters (debug/trace sources).
- Grants one requester at a time, round-robin, and holds the grant for a whole frame.
- A frame is one header byte followed by that requester's payload bytes, up to its `last` byte.
- Sits directly in front of the `uart` instance: drives `data_i`/`data_valid_i` and watches `ready_o`.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hA;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StHdrPulse,
        StHdrWait,
        StPayLoad,
        StPayPulse,
        StPayWait
    } state_e;

    // Header byte announces which requester owns the frame that follows.
    function automatic logic [7:0] hdr_byte(input logic [3:0] magic, input idx_t idx);
        return {magic, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; priority starts one past the last winner.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] gnt,
    output idx_t         idx,
    output logic         any
);

    idx_t ptr_q;
    int   cand;
    logic found;

    // Scan requests starting at the pointer and pick the first one set.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < int'(N); off++) begin
            cand = (int'(ptr_q) + off) % int'(N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = idx_t'(cand);
            end
        end
    end

    assign any = |req;

    // Advance the pointer past the winner only when a grant is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (update) begin
            ptr_q <= (idx == idx_t'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters, one frame at a time.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter logic [3:0]  HDR_MAGIC   = HDR_MAGIC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ*8-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         uart_data_o,
    output logic               uart_valid_o,
    input  logic               uart_ready_i,
    output logic               busy_o,
    output logic               trunc_o
);

    localparam int unsigned     CNT_W   = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD);

    state_e             state_q, state_d;
    logic               rdy_q;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               trunc_q, trunc_d;

    logic [N_REQ-1:0]   arb_gnt;
    idx_t               arb_idx;
    logic               arb_any;
    logic               arb_update;

    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid_i),
        .update (arb_update),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    // Route the granted requester's byte, valid and last flag.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q[i]) begin
                sel_data  = req_data_i[8*i +: 8];
                sel_valid = req_valid_i[i];
                sel_last  = req_last_i[i];
            end
        end
    end

    // Frame sequencing: header, then payload bytes, each pulsed once the UART is free.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        trunc_d      = trunc_q;
        arb_update   = 1'b0;
        req_ready_o  = '0;
        uart_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rdy_q && arb_any) begin
                    arb_update = 1'b1;
                    grant_d    = arb_gnt;
                    data_d     = hdr_byte(HDR_MAGIC, arb_idx);
                    cnt_d      = '0;
                    last_d     = 1'b0;
                    state_d    = StHdrPulse;
                end
            end
            StHdrPulse: begin
                uart_valid_o = 1'b1;
                state_d      = StHdrWait;
            end
            StHdrWait: begin
                if (rdy_q) begin
                    state_d = StPayLoad;
                end
            end
            StPayLoad: begin
                req_ready_o = grant_q;
                if (sel_valid) begin
                    data_d  = sel_data;
                    cnt_d   = cnt_q + 1'b1;
                    last_d  = sel_last;
                    // Byte that fills the frame without last: still sent, frame cut after it.
                    if (!sel_last && (cnt_q + 1'b1 == CNT_MAX)) begin
                        trunc_d = 1'b1;
                    end
                    state_d = StPayPulse;
                end
            end
            StPayPulse: begin
                uart_valid_o = 1'b1;
                state_d      = StPayWait;
            end
            StPayWait: begin
                if (rdy_q) begin
                    if (last_q || (cnt_q == CNT_MAX)) begin
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StPayLoad;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; ready is registered to break the loop through the UART.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rdy_q   <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= uart_ready_i;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            trunc_q <= trunc_d;
        end
    end

    assign uart_data_o = data_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != StIdle);
    assign trunc_o     = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART timing model.
module tb_uart_tx_arbiter;

    localparam int CHAR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req_data_i  = '0;
    logic [3:0]  req_valid_i = '0;
    logic [3:0]  req_last_i  = '0;
    logic [3:0]  req_ready_o;
    logic [3:0]  grant_o;
    logic [7:0]  uart_data_o;
    logic        uart_valid_o;
    logic        uart_ready_i;
    logic        busy_o;
    logic        trunc_o;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .MAX_PAYLOAD (2),
        .HDR_MAGIC   (4'hA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data_i   (req_data_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .uart_data_o  (uart_data_o),
        .uart_valid_o (uart_valid_o),
        .uart_ready_i (uart_ready_i),
        .busy_o       (busy_o),
        .trunc_o      (trunc_o)
    );

    always #5 clk = ~clk;

    // UART model: busy for CHAR cycles after a pulse, ready drops combinationally on valid.
    int ucnt = 0;
    always @(posedge clk) begin
        if (uart_valid_o) ucnt <= CHAR;
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign uart_ready_i = (ucnt == 0) && !uart_valid_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] wire_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Capture the wire and check handshake protocol on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (uart_valid_o) begin
                wire_q.push_back(uart_data_o);
                check("no_back_to_back_valid", 32'(prev_valid), 32'd0);
                check("valid_after_ready", 32'(prev_ready), 32'd1);
            end
            if (req_ready_o != 4'b0000) begin
                check("ready_onehot_in_grant",
                      32'(($countones(req_ready_o) == 1) && ((req_ready_o & ~grant_o) == 4'b0)),
                      32'd1);
            end
        end
        prev_valid = uart_valid_o;
        prev_ready = uart_ready_i;
    end

    // Wait for IDLE with the UART free, then one more cycle so the registered ready is high.
    task automatic wait_rdy();
        int n;
        n = 0;
        @(negedge clk);
        while (!(uart_ready_i && !busy_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail("wait_rdy");
        @(negedge clk);
    endtask

    task automatic present(input int r, input logic [7:0] b, input logic l);
        req_data_i[8*r +: 8] = b;
        req_valid_i[r]       = 1'b1;
        req_last_i[r]        = l;
    endtask

    task automatic hold_until_taken(input int r);
        int n;
        n = 0;
        while (!req_ready_o[r] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) timeout_fail("byte_accept");
        @(negedge clk);
        req_valid_i[r] = 1'b0;
        req_last_i[r]  = 1'b0;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        @(negedge clk);
        present(r, b, l);
        hold_until_taken(r);
    endtask

    task automatic expect_wire(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (wire_q.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (wire_q.size() == 0) timeout_fail(name);
        else check(name, 32'(wire_q.pop_front()), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(uart_valid_o), 32'd0);
        check({tag, "_data"},  32'(uart_data_o), 32'h00);
        check({tag, "_grant"}, 32'(grant_o), 32'h0);
        check({tag, "_ready"}, 32'(req_ready_o), 32'h0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_trunc"}, 32'(trunc_o), 32'd0);
    endtask

    typedef struct {
        int         r;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] hdr;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int bad;
        int n;

        vecs[0] = '{r: 2, n: 2, b0: 8'h41, b1: 8'h42, hdr: 8'hA2, gnt: 4'b0100};
        vecs[1] = '{r: 0, n: 1, b0: 8'h5A, b1: 8'h00, hdr: 8'hA0, gnt: 4'b0001};
        vecs[2] = '{r: 3, n: 2, b0: 8'h00, b1: 8'hFF, hdr: 8'hA3, gnt: 4'b1000};
        vecs[3] = '{r: 1, n: 1, b0: 8'hC3, b1: 8'h00, hdr: 8'hA1, gnt: 4'b0010};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single-requester frames from the table.
        for (int i = 0; i < 4; i++) begin
            wait_rdy();
            present(vecs[i].r, vecs[i].b0, vecs[i].n == 1);
            @(negedge clk);
            check("hdr_latency_valid", 32'(uart_valid_o), 32'd1);
            check("hdr_latency_data", 32'(uart_data_o), 32'(vecs[i].hdr));
            check("grant_at_hdr", 32'(grant_o), 32'(vecs[i].gnt));
            hold_until_taken(vecs[i].r);
            if (vecs[i].n == 2) push(vecs[i].r, vecs[i].b1, 1'b1);
            check("grant_held", 32'(grant_o), 32'(vecs[i].gnt));
            expect_wire("wire_hdr", vecs[i].hdr);
            expect_wire("wire_b0", vecs[i].b0);
            if (vecs[i].n == 2) expect_wire("wire_b1", vecs[i].b1);
            wait_rdy();
            check("grant_idle", 32'(grant_o), 32'h0);
            check("busy_idle", 32'(busy_o), 32'd0);
            check("no_trunc", 32'(trunc_o), 32'd0);
        end

        // Simultaneous 0 and 1: pointer sits at 2, so 0 goes first.
        wait_rdy();
        fork
            push(0, 8'h11, 1'b1);
            push(1, 8'h22, 1'b1);
        join
        expect_wire("sim_hdr0", 8'hA0);
        expect_wire("sim_b0", 8'h11);
        expect_wire("sim_hdr1", 8'hA1);
        expect_wire("sim_b1", 8'h22);

        // After granting 1, requester 3 beats 0.
        wait_rdy();
        fork
            push(0, 8'h44, 1'b1);
            push(3, 8'h33, 1'b1);
        join
        expect_wire("rr_hdr3", 8'hA3);
        expect_wire("rr_b3", 8'h33);
        expect_wire("rr_hdr0", 8'hA0);
        expect_wire("rr_b0", 8'h44);

        // Granted requester stalls mid-frame while another requester waits.
        wait_rdy();
        push(2, 8'h71, 1'b0);
        present(0, 8'h55, 1'b1);
        n = 0;
        while (!req_ready_o[2] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout_fail("stall_reach_load");
        req_valid_i[2] = 1'b0;
        bad = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (uart_valid_o || !busy_o || grant_o != 4'b0100 || req_ready_o != 4'b0100) bad++;
        end
        check("stall_quiet_cycles_bad", 32'(bad), 32'd0);
        check("stall_busy", 32'(busy_o), 32'd1);
        push(2, 8'h72, 1'b1);
        hold_until_taken(0);
        expect_wire("stall_hdr", 8'hA2);
        expect_wire("stall_b0", 8'h71);
        expect_wire("stall_b1", 8'h72);
        expect_wire("waiter_hdr", 8'hA0);
        expect_wire("waiter_b0", 8'h55);

        // MAX_PAYLOAD = 2: three bytes split into two frames.
        wait_rdy();
        check("trunc_before", 32'(trunc_o), 32'd0);
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        check("trunc_set", 32'(trunc_o), 32'd1);
        push(1, 8'h33, 1'b1);
        expect_wire("trunc_hdr_a", 8'hA1);
        expect_wire("trunc_d0", 8'h31);
        expect_wire("trunc_d1", 8'h32);
        expect_wire("trunc_hdr_b", 8'hA1);
        expect_wire("trunc_d2", 8'h33);
        wait_rdy();
        check("trunc_sticky", 32'(trunc_o), 32'd1);

        // Reset while waiting for the UART after a payload pulse.
        wait_rdy();
        push(3, 8'h61, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_next");
        rst = 1'b0;
        expect_wire("pre_rst_hdr", 8'hA3);
        expect_wire("pre_rst_b0", 8'h61);
        wait_rdy();
        present(3, 8'h62, 1'b1);
        @(negedge clk);
        check("post_rst_hdr_valid", 32'(uart_valid_o), 32'd1);
        check("post_rst_hdr", 32'(uart_data_o), 32'hA3);
        hold_until_taken(3);
        expect_wire("post_rst_wire_hdr", 8'hA3);
        expect_wire("post_rst_wire_b0", 8'h62);
        wait_rdy();
        check("post_rst_idle", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
